// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the instruction-fetch front end.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned WBYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        FETCH,
        SQUASH,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t npc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request port and IF/ID handoff of the fetch unit.
interface fetch_unit_if;
    import cpu_types_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  ihit;
    word_t iload;

    logic  if_valid;
    word_t if_instr;
    word_t if_pc;
    word_t if_npc;
    logic  if_ready;

    modport master (
        output iREN, iaddr, if_valid, if_instr, if_pc, if_npc,
        input  ihit, iload, if_ready
    );

    modport slave (
        input  iREN, iaddr, if_valid, if_instr, if_pc, if_npc,
        output ihit, iload, if_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched entries between fetch and decode; flush wins over push/pop.
module fetch_buffer
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC sequencing, imem requests, redirect squash and halt.
// Define FETCH_PERF_EN to add the stall/squash performance counters.
//
// state  | meaning
// FETCH  | issuing reads while buffer has room and no halt seen
// SQUASH | redirect arrived mid-request; wait for ihit, drop data, load target
// HALTED | no more requests, redirects ignored; buffer still drains
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned WBYTES    = WBYTES_DEFAULT
) (
    input  logic         CLK,
    input  logic         nRST,
    input  word_t        pc_out,
    output logic         pc_EN,
    output word_t        pc_in,
    input  logic         redirect,
    input  word_t        redirect_pc,
    input  logic         halt,
`ifdef FETCH_PERF_EN
    output word_t        perf_stall_cnt,
    output word_t        perf_squash_cnt,
`endif
    fetch_unit_if.master fif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    fetch_state_t  state;
    fetch_state_t  next_state;
    word_t         pend_target;
    word_t         pend_next;
    logic          halt_seen;
    logic          req_out;
    logic          iren_raw;
    logic          pc_en_raw;
    logic          push;
    logic          flush;
    logic          pop;
    word_t         pc_inc;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;

    assign pc_inc    = pc_out + word_t'(WBYTES);
    assign push_data = '{pc: pc_out, npc: pc_inc, instr: fif.iload};
    assign pop       = fif.if_valid && fif.if_ready;

    always_comb begin
        next_state = state;
        pend_next  = pend_target;
        iren_raw   = 1'b0;
        pc_en_raw  = 1'b0;
        pc_in      = pc_inc;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state)
            FETCH: begin
                // an outstanding request keeps iREN up even after halt is seen
                iren_raw = req_out || ((count < FULL_CNT) && !halt_seen);
                if (redirect) begin
                    flush = 1'b1;
                    pc_in = redirect_pc;
                    if (iren_raw && !fif.ihit) begin
                        next_state = SQUASH;
                        pend_next  = redirect_pc;
                    end else begin
                        pc_en_raw = 1'b1;
                    end
                end else if (iren_raw && fif.ihit) begin
                    push      = 1'b1;
                    pc_en_raw = 1'b1;
                end else if (halt_seen && !iren_raw) begin
                    next_state = HALTED;
                end
            end
            SQUASH: begin
                iren_raw = 1'b1;
                if (redirect) begin
                    flush     = 1'b1;
                    pend_next = redirect_pc;
                end
                if (fif.ihit) begin
                    pc_en_raw  = 1'b1;
                    pc_in      = redirect ? redirect_pc : pend_target;
                    next_state = FETCH;
                end
            end
            HALTED: begin
            end
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            pend_target <= '0;
            halt_seen   <= 1'b0;
            req_out     <= 1'b0;
        end else begin
            state       <= next_state;
            pend_target <= pend_next;
            halt_seen   <= halt_seen || halt;
            req_out     <= iren_raw && !fif.ihit;
        end
    end

    assign fif.iREN  = iren_raw && nRST;
    assign pc_EN     = pc_en_raw && nRST;
    assign fif.iaddr = pc_out;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );

    assign fif.if_valid = (count != '0);
    assign fif.if_instr = head.instr;
    assign fif.if_pc    = head.pc;
    assign fif.if_npc   = head.npc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_stall_cnt  <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (fif.iREN && !fif.ihit && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush && (perf_squash_cnt != '1)) begin
                perf_squash_cnt <= perf_squash_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC loads and decode entries are queued by stimulus.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    word_t pc_reg;
    logic  pc_EN;
    word_t pc_in;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    logic  pc_force;
    word_t pc_force_val;
`ifdef FETCH_PERF_EN
    word_t perf_stall_cnt;
    word_t perf_squash_cnt;
`endif

    fetch_unit_if bus();

    int errors = 0;
    int checks = 0;
    word_t        exp_pc_q[$];
    fetch_entry_t exp_if_q[$];
    word_t        mon_pc;
    fetch_entry_t mon_ent;

    always #5 CLK = ~CLK;

    assign bus.iload = bus.iaddr ^ 32'h5A5A_0000;

    fetch_unit #(.BUF_DEPTH(2), .WBYTES(4)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .pc_out      (pc_reg),
        .pc_EN       (pc_EN),
        .pc_in       (pc_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
`ifdef FETCH_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_squash_cnt (perf_squash_cnt),
`endif
        .fif         (bus)
    );

    // program_counter stand-in
    always @(posedge CLK) begin
        if (pc_force) pc_reg <= pc_force_val;
        else if (pc_EN) pc_reg <= pc_in;
    end

    always @(negedge CLK) begin
        if (pc_EN === 1'b1) begin
            checks++;
            if (exp_pc_q.size() == 0) begin
                errors++;
                $display("FAIL pc_load_unexpected: pc_in=%h, no load expected", pc_in);
            end else begin
                mon_pc = exp_pc_q.pop_front();
                if (pc_in !== mon_pc) begin
                    errors++;
                    $display("FAIL pc_load: pc_in=%h expected %h", pc_in, mon_pc);
                end
            end
        end
        if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
            checks++;
            if (exp_if_q.size() == 0) begin
                errors++;
                $display("FAIL if_entry_unexpected: pc=%h instr=%h, no entry expected", bus.if_pc, bus.if_instr);
            end else begin
                mon_ent = exp_if_q.pop_front();
                if (bus.if_pc !== mon_ent.pc || bus.if_npc !== mon_ent.npc || bus.if_instr !== mon_ent.instr) begin
                    errors++;
                    $display("FAIL if_entry: got pc=%h npc=%h instr=%h expected pc=%h npc=%h instr=%h",
                             bus.if_pc, bus.if_npc, bus.if_instr, mon_ent.pc, mon_ent.npc, mon_ent.instr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic exp_if(input word_t pc, input word_t npc);
        exp_if_q.push_back('{pc: pc, npc: npc, instr: pc ^ 32'h5A5A_0000});
    endtask

    task automatic do_reset(input word_t pc0);
        nRST         = 1'b0;
        pc_force     = 1'b1;
        pc_force_val = pc0;
        bus.ihit     = 1'b0;
        bus.if_ready = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        halt         = 1'b0;
        #2;
        chk("rst_iren", 32'(bus.iREN), 32'd0);
        chk("rst_pc_en", 32'(pc_EN), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        step();
        step();
        pc_force = 1'b0;
        nRST     = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_pc_q.size() != 0 || exp_if_q.size() != 0) && n < 20) begin
            step();
            n++;
        end
        chk({name, "_drained"}, 32'(exp_pc_q.size() + exp_if_q.size()), 32'd0);
        exp_pc_q.delete();
        exp_if_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // sequential fetch with decode always ready
        do_reset(32'h0);
        bus.if_ready = 1'b1;
        bus.ihit     = 1'b1;
        exp_pc_q.push_back(32'd4);
        exp_pc_q.push_back(32'd8);
        exp_pc_q.push_back(32'd12);
        exp_if(32'd0, 32'd4);
        exp_if(32'd4, 32'd8);
        exp_if(32'd8, 32'd12);
        settle();
        chk("t1_iaddr", bus.iaddr, 32'd0);
        chk("t1_iren", 32'(bus.iREN), 32'd1);
        step(); step(); step();
        bus.ihit = 1'b0;
        settle();
        chk("t1_iaddr_next", bus.iaddr, 32'd12);
        chk("t1_head_pc", bus.if_pc, 32'd8);
        chk("t1_head_npc", bus.if_npc, 32'd12);
        drain("t1");

        // buffer fills, fetch stalls, one pop restarts fetch
        do_reset(32'h0);
        bus.ihit = 1'b1;
        exp_pc_q.push_back(32'd4);
        exp_pc_q.push_back(32'd8);
        step(); step();
        settle();
        chk("t2_full_iren", 32'(bus.iREN), 32'd0);
        chk("t2_full_pc_en", 32'(pc_EN), 32'd0);
        chk("t2_full_iaddr", bus.iaddr, 32'd8);
        chk("t2_full_valid", 32'(bus.if_valid), 32'd1);
        step();
        bus.ihit     = 1'b0;
        bus.if_ready = 1'b1;
        exp_if(32'd0, 32'd4);
        settle();
        chk("t2_pop_iren", 32'(bus.iREN), 32'd0);
        step();
        bus.if_ready = 1'b0;
        bus.ihit     = 1'b1;
        exp_pc_q.push_back(32'd12);
        settle();
        chk("t2_restart_iren", 32'(bus.iREN), 32'd1);
        chk("t2_restart_iaddr", bus.iaddr, 32'd8);
        chk("t2_head_pc", bus.if_pc, 32'd4);
        step();
        bus.ihit     = 1'b0;
        bus.if_ready = 1'b1;
        exp_if(32'd4, 32'd8);
        exp_if(32'd8, 32'd12);
        settle();
        chk("t2_refull_iren", 32'(bus.iREN), 32'd0);
        drain("t2");

        // redirect while a request is outstanding
        do_reset(32'h40);
        bus.if_ready = 1'b1;
        redirect     = 1'b1;
        redirect_pc  = 32'h200;
        settle();
        chk("t3_iren", 32'(bus.iREN), 32'd1);
        chk("t3_pc_en", 32'(pc_EN), 32'd0);
        step();
        redirect = 1'b0;
        settle();
        chk("t3_sq_iaddr", bus.iaddr, 32'h40);
        chk("t3_sq_iren", 32'(bus.iREN), 32'd1);
        chk("t3_sq_pc_en", 32'(pc_EN), 32'd0);
        step(); step();
        bus.ihit = 1'b1;
        exp_pc_q.push_back(32'h200);
        step();
        bus.ihit = 1'b0;
        settle();
        chk("t3_new_iaddr", bus.iaddr, 32'h200);
        chk("t3_new_iren", 32'(bus.iREN), 32'd1);
        chk("t3_no_push", 32'(bus.if_valid), 32'd0);
        drain("t3");

        // redirects flush a full buffer and drop a coincident ihit
        do_reset(32'h18);
        bus.ihit = 1'b1;
        exp_pc_q.push_back(32'h1C);
        exp_pc_q.push_back(32'h20);
        step(); step();
        bus.ihit    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        exp_pc_q.push_back(32'h20);
        settle();
        chk("t4_two_held", 32'(bus.if_valid), 32'd1);
        chk("t4_full_iren", 32'(bus.iREN), 32'd0);
        step();
        redirect_pc  = 32'h100;
        bus.ihit     = 1'b1;
        bus.if_ready = 1'b1;
        exp_pc_q.push_back(32'h100);
        settle();
        chk("t4_flushed", 32'(bus.if_valid), 32'd0);
        chk("t4_iaddr", bus.iaddr, 32'h20);
        step();
        redirect = 1'b0;
        bus.ihit = 1'b0;
        settle();
        chk("t4_dropped", 32'(bus.if_valid), 32'd0);
        chk("t4_new_iaddr", bus.iaddr, 32'h100);
        drain("t4");

        // halt with an outstanding request
        do_reset(32'h10);
        halt = 1'b1;
        settle();
        chk("t5_iren_c1", 32'(bus.iREN), 32'd1);
        step();
        settle();
        chk("t5_iren_held", 32'(bus.iREN), 32'd1);
        step();
        bus.ihit = 1'b1;
        exp_pc_q.push_back(32'h14);
        step();
        bus.ihit = 1'b0;
        settle();
        chk("t5_iren_off", 32'(bus.iREN), 32'd0);
        chk("t5_pushed", 32'(bus.if_valid), 32'd1);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        settle();
        chk("t5_redir_pc_en", 32'(pc_EN), 32'd0);
        chk("t5_redir_iren", 32'(bus.iREN), 32'd0);
        step();
        redirect     = 1'b0;
        bus.if_ready = 1'b1;
        exp_if(32'h10, 32'h14);
        settle();
        chk("t5_not_flushed", 32'(bus.if_valid), 32'd1);
        repeat (3) step();
        settle();
        chk("t5_stays_off", 32'(bus.iREN), 32'd0);
        chk("t5_drained_buf", 32'(bus.if_valid), 32'd0);
        chk("t5_iaddr", bus.iaddr, 32'h14);
        drain("t5");

        // PC wrap at the top of the address space
        do_reset(32'hFFFF_FFFC);
        bus.ihit     = 1'b1;
        bus.if_ready = 1'b1;
        exp_pc_q.push_back(32'h0);
        exp_if(32'hFFFF_FFFC, 32'h0);
        step();
        bus.ihit = 1'b0;
        settle();
        chk("t6_if_npc", bus.if_npc, 32'h0);
        chk("t6_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        chk("t6_iaddr", bus.iaddr, 32'h0);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
